// File: rtl/rsa_multicore_ctrl_pkg.sv
// Shared constants for the multi-core RSA controller: opcodes, command
// field layout, operand slot indices and FSM state encoding.
package rsa_ctrl_pkg;

   localparam logic [1:0] CMD_READ    = 2'd0;
   localparam logic [1:0] CMD_ENCRYPT = 2'd1;
   localparam logic [1:0] CMD_WRITE   = 2'd2;
   localparam logic [1:0] CMD_DECRYPT = 2'd3;

   // Command word layout
   localparam int OP_LSB   = 0;
   localparam int OP_W     = 2;
   localparam int SLOT_LSB = 4;
   localparam int SLOT_W   = 4;
   localparam int CORE_LSB = 8;
   localparam int CORE_W   = 8;

   localparam int SLOT_MSG    = 0;
   localparam int SLOT_EXP    = 1;
   localparam int SLOT_N      = 2;
   localparam int SLOT_RMODN  = 3;
   localparam int SLOT_R2MODN = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX       = 3'd1,
      ST_START    = 3'd2,
      ST_WAIT_RES = 3'd3,
      ST_TX       = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

endpackage

// File: rtl/rsa_multicore_ctrl_if.sv
// ARM-side command / done / data handshake bundle. The ARM drives the
// master modport, the controller sits on the slave modport.
interface rsa_multicore_ctrl_if #(parameter int DATA_W = 1024);

   logic [31:0]       arm_to_fpga_cmd;
   logic              arm_to_fpga_cmd_valid;
   logic              fpga_to_arm_done;
   logic              fpga_to_arm_done_read;
   logic              arm_to_fpga_data_valid;
   logic              arm_to_fpga_data_ready;
   logic [DATA_W-1:0] arm_to_fpga_data;
   logic              fpga_to_arm_data_valid;
   logic              fpga_to_arm_data_ready;
   logic [DATA_W-1:0] fpga_to_arm_data;

   modport master (
      output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
             arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
      input  fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
             fpga_to_arm_data
   );

   modport slave (
      input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, fpga_to_arm_done_read,
             arm_to_fpga_data_valid, arm_to_fpga_data, fpga_to_arm_data_ready,
      output fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
             fpga_to_arm_data
   );

endinterface

// File: rtl/rsa_multicore_ctrl.sv
// ARM command/data controller for NUM_CORES modexp cores: loads shared
// operand slots, fires non-blocking starts and returns per-core results.
module rsa_multicore_ctrl
   import rsa_ctrl_pkg::*;
#(
   parameter int DATA_W    = 1024,
   parameter int NUM_CORES = 2,
   parameter int NUM_OPS   = 5
) (
   input  logic                          clk,
   input  logic                          resetn,
   rsa_multicore_ctrl_if.slave           arm,
   output logic [NUM_OPS*DATA_W-1:0]     op_regs,
   output logic [NUM_CORES-1:0]          core_start,
   output logic                          core_decrypt,
   input  logic [NUM_CORES-1:0]          core_busy,
   input  logic [NUM_CORES*DATA_W-1:0]   core_result,
   input  logic [NUM_CORES-1:0]          core_result_valid,
   output logic [NUM_CORES-1:0]          core_result_ack,
   output logic [3:0]                    leds
);

   state_t state, state_nx;

   logic [OP_W-1:0]              op_q;
   logic [SLOT_W-1:0]            slot_q;
   logic [CORE_W-1:0]            core_q;
   logic                         err_q;
   logic [NUM_OPS-1:0][DATA_W-1:0] ops_q;
   logic [DATA_W-1:0]            out_q;

   logic [OP_W-1:0]   cmd_op;
   logic [SLOT_W-1:0] cmd_slot;
   logic [CORE_W-1:0] cmd_core;
   logic              cmd_bad;

   logic              sel_busy, sel_rvld;
   logic [DATA_W-1:0] sel_res;
   logic              rx_fire, tx_fire, start_ok;

   assign cmd_op   = arm.arm_to_fpga_cmd[OP_LSB   +: OP_W];
   assign cmd_slot = arm.arm_to_fpga_cmd[SLOT_LSB +: SLOT_W];
   assign cmd_core = arm.arm_to_fpga_cmd[CORE_LSB +: CORE_W];

   // Out-of-range core or slot is caught at decode so nothing downstream
   // ever indexes past the core/slot arrays.
   assign cmd_bad = (32'(cmd_core) >= NUM_CORES) ||
                    ((cmd_op == CMD_READ) && (32'(cmd_slot) >= NUM_OPS));

   always_comb begin
      sel_busy = 1'b0;
      sel_rvld = 1'b0;
      sel_res  = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (32'(core_q) == i) begin
            sel_busy = core_busy[i];
            sel_rvld = core_result_valid[i];
            sel_res  = core_result[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rx_fire  = (state == ST_RX) && arm.arm_to_fpga_data_valid;
   assign tx_fire  = (state == ST_TX) && arm.fpga_to_arm_data_ready;
   assign start_ok = (state == ST_START) && !sel_busy && !sel_rvld;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (arm.arm_to_fpga_cmd_valid) begin
               if (cmd_bad)                    state_nx = ST_DONE;
               else if (cmd_op == CMD_READ)    state_nx = ST_RX;
               else if (cmd_op == CMD_WRITE)   state_nx = ST_WAIT_RES;
               else                            state_nx = ST_START;
            end
         end
         ST_RX:       if (rx_fire) state_nx = ST_DONE;
         ST_START:    state_nx = ST_DONE;
         ST_WAIT_RES: if (sel_rvld) state_nx = ST_TX;
         ST_TX:       if (tx_fire) state_nx = ST_DONE;
         ST_DONE:     if (arm.fpga_to_arm_done_read) state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      core_start      = '0;
      core_result_ack = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (32'(core_q) == i) begin
            core_start[i]      = start_ok;
            core_result_ack[i] = tx_fire;
         end
      end
   end

   assign core_decrypt               = start_ok & op_q[1];
   assign arm.arm_to_fpga_data_ready = (state == ST_RX);
   assign arm.fpga_to_arm_data_valid = (state == ST_TX);
   assign arm.fpga_to_arm_done       = (state == ST_DONE);
   assign arm.fpga_to_arm_data       = out_q;
   assign op_regs                    = ops_q;
   assign leds                       = {err_q, state};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         op_q   <= '0;
         slot_q <= '0;
         core_q <= '0;
         err_q  <= 1'b0;
         ops_q  <= '0;
         out_q  <= '0;
      end else begin
         state <= state_nx;
         if ((state == ST_IDLE) && arm.arm_to_fpga_cmd_valid) begin
            op_q   <= cmd_op;
            slot_q <= cmd_slot;
            core_q <= cmd_core;
            if (cmd_bad) err_q <= 1'b1;
         end
         // Starting a core that is computing or still holding a result
         // would clobber work in flight, so it is refused and flagged.
         if ((state == ST_START) && !start_ok) err_q <= 1'b1;
         if (rx_fire) begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (32'(slot_q) == i) ops_q[i] <= arm.arm_to_fpga_data;
            end
            if (slot_q == SLOT_W'(SLOT_MSG)) err_q <= 1'b0;
         end
         if ((state == ST_WAIT_RES) && sel_rvld) out_q <= sel_res;
      end
   end

endmodule

// File: tb/tb_rsa_multicore_ctrl.sv
// Directed bench for rsa_multicore_ctrl with a transaction-level model of
// operand slots, error flag and expected start/ack pulses.
module tb_rsa_multicore_ctrl;
   import rsa_ctrl_pkg::*;

   localparam int DATA_W = 1024;
   localparam int NC     = 2;
   localparam int NO     = 5;
   typedef logic [DATA_W-1:0] word_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   rsa_multicore_ctrl_if #(.DATA_W(DATA_W)) arm ();

   logic [NO*DATA_W-1:0] op_regs;
   logic [NC-1:0]        core_start, core_result_ack;
   logic                 core_decrypt;
   logic [3:0]           leds;
   logic [NC-1:0]        core_busy = '0;
   logic [NC-1:0]        core_result_valid = '0;
   logic [NC*DATA_W-1:0] core_result = '0;

   rsa_multicore_ctrl #(.DATA_W(DATA_W), .NUM_CORES(NC), .NUM_OPS(NO)) dut (
      .clk(clk), .resetn(resetn), .arm(arm), .op_regs(op_regs),
      .core_start(core_start), .core_decrypt(core_decrypt), .core_busy(core_busy),
      .core_result(core_result), .core_result_valid(core_result_valid),
      .core_result_ack(core_result_ack), .leds(leds)
   );

   int    checks = 0;
   int    errors = 0;
   word_t exp_ops [NO];
   logic  exp_err;
   word_t exp_res;
   word_t res_val [NC];
   logic [NC:0]   start_q [$];
   logic [NC-1:0] ack_q   [$];

   // Core model: busy for a fixed latency after start, then holds its
   // result until acknowledged.
   int cnt [NC] = '{default: 0};
   logic [NC-1:0] cm_st, cm_ak;
   always @(posedge clk) begin
      cm_st = core_start;
      cm_ak = core_result_ack;
      #1;
      for (int k = 0; k < NC; k++) begin
         if (cm_ak[k]) core_result_valid[k] = 1'b0;
         if (cm_st[k]) begin
            core_busy[k] = 1'b1;
            cnt[k] = (k == 0) ? 20 : 50;
         end else if (cnt[k] > 0) begin
            cnt[k]--;
            if (cnt[k] == 0) begin
               core_busy[k] = 1'b0;
               core_result_valid[k] = 1'b1;
               core_result[k*DATA_W +: DATA_W] = res_val[k];
            end
         end
      end
   end

   task automatic chk(input string nm, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_loop();
      forever begin
         @(negedge clk);
         if (resetn) begin
            for (int i = 0; i < NO; i++)
               chk($sformatf("op_regs[%0d]", i), op_regs[i*DATA_W +: DATA_W], exp_ops[i]);
            if (core_start != '0) begin
               if (start_q.size() == 0) chk("spurious core_start", word_t'(core_start), '0);
               else chk("core_start/decrypt", word_t'({core_decrypt, core_start}), word_t'(start_q.pop_front()));
            end
            if (core_result_ack != '0) begin
               if (ack_q.size() == 0) chk("spurious core_result_ack", word_t'(core_result_ack), '0);
               else chk("core_result_ack", word_t'(core_result_ack), word_t'(ack_q.pop_front()));
            end
            if (arm.fpga_to_arm_done) chk("error flag at done", word_t'(leds[3]), word_t'(exp_err));
            if (arm.fpga_to_arm_data_valid) chk("fpga_to_arm_data", arm.fpga_to_arm_data, exp_res);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string nm);
      chk({nm, " done"}, word_t'(arm.fpga_to_arm_done), '0);
      chk({nm, " data_ready"}, word_t'(arm.arm_to_fpga_data_ready), '0);
      chk({nm, " data_valid"}, word_t'(arm.fpga_to_arm_data_valid), '0);
      chk({nm, " out data"}, arm.fpga_to_arm_data, '0);
      for (int i = 0; i < NO; i++) chk({nm, " op slot"}, op_regs[i*DATA_W +: DATA_W], '0);
      chk({nm, " core_start"}, word_t'(core_start), '0);
      chk({nm, " core_decrypt"}, word_t'(core_decrypt), '0);
      chk({nm, " core_result_ack"}, word_t'(core_result_ack), '0);
      chk({nm, " leds"}, word_t'(leds), '0);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [3:0] slot, input logic [7:0] core);
      arm.arm_to_fpga_cmd = {16'h0, core, slot, 2'b00, op};
      arm.arm_to_fpga_cmd_valid = 1'b1;
      tick();
      arm.arm_to_fpga_cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int maxc, output int n);
      n = 0;
      while (!arm.fpga_to_arm_done && n < maxc) begin
         tick();
         n++;
      end
      chk({nm, " done raised"}, word_t'(arm.fpga_to_arm_done), word_t'(1));
      chk({nm, " leds state DONE"}, word_t'(leds[2:0]), word_t'(5));
      arm.fpga_to_arm_done_read = 1'b1;
      tick();
      arm.fpga_to_arm_done_read = 1'b0;
      chk({nm, " done cleared"}, word_t'(arm.fpga_to_arm_done), '0);
   endtask

   task automatic do_read(input string nm, input int slot, input word_t d);
      int n;
      send_cmd(CMD_READ, 4'(slot), 8'h0);
      if (slot >= NO) begin
         exp_err = 1'b1;
      end else begin
         chk({nm, " in RX"}, word_t'(leds[2:0]), word_t'(1));
         arm.arm_to_fpga_data = d;
         arm.arm_to_fpga_data_valid = 1'b1;
         tick();
         arm.arm_to_fpga_data_valid = 1'b0;
         exp_ops[slot] = d;
         if (slot == SLOT_MSG) exp_err = 1'b0;
      end
      wait_done(nm, 4, n);
   endtask

   task automatic do_start(input string nm, input logic [1:0] op, input int core, input bit ok);
      int n;
      if (ok) start_q.push_back({op[1], NC'(1 << core)});
      send_cmd(op, 4'h0, 8'(core));
      if (!ok) exp_err = 1'b1;
      wait_done(nm, 4, n);
      chk({nm, " done latency"}, word_t'(n), word_t'((core >= NC) ? 0 : 1));
   endtask

   task automatic do_write(input string nm, input int core);
      int n;
      exp_res = res_val[core];
      ack_q.push_back(NC'(1 << core));
      arm.fpga_to_arm_data_ready = 1'b1;
      send_cmd(CMD_WRITE, 4'h0, 8'(core));
      wait_done(nm, 100, n);
      arm.fpga_to_arm_data_ready = 1'b0;
   endtask

   initial begin
      int n;
      arm.arm_to_fpga_cmd = '0;
      arm.arm_to_fpga_cmd_valid = 1'b0;
      arm.fpga_to_arm_done_read = 1'b0;
      arm.arm_to_fpga_data_valid = 1'b0;
      arm.arm_to_fpga_data = '0;
      arm.fpga_to_arm_data_ready = 1'b0;
      res_val[0] = 'h1234;
      res_val[1] = 'hABCD;
      exp_err = 1'b0;
      exp_res = '0;
      for (int i = 0; i < NO; i++) exp_ops[i] = '0;
      fork
         cmp_loop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      resetn = 1'b1;
      tick();

      // Operand loads
      for (int i = 0; i < NO; i++) do_read("load", i, word_t'((i + 1) * 'h1111));
      chk("slot2 literal", op_regs[2*DATA_W +: DATA_W], 'h3333);
      chk("slot4 literal", op_regs[4*DATA_W +: DATA_W], 'h5555);

      // Concurrent starts, then a start to the still-busy core 0
      do_start("enc core0", CMD_ENCRYPT, 0, 1'b1);
      do_start("dec core1", CMD_DECRYPT, 1, 1'b1);
      do_start("enc busy core0", CMD_ENCRYPT, 0, 1'b0);
      chk("leds after busy start", word_t'(leds), 'h8);
      do_read("clear err", SLOT_MSG, 'h1111);
      chk("leds after err clear", word_t'(leds), '0);

      // Results
      do_write("write core0", 0);
      chk("core0 result literal", arm.fpga_to_arm_data, 'h1234);
      do_write("write core1", 1);
      chk("core1 result literal", arm.fpga_to_arm_data, 'hABCD);

      // Range errors
      do_start("enc core5", CMD_ENCRYPT, 5, 1'b0);
      chk("leds after bad core", word_t'(leds), 'h8);
      do_read("read slot7", 7, 'hDEAD);
      chk("leds after bad slot", word_t'(leds), 'h8);
      do_read("clear err 2", SLOT_MSG, 'h1111);

      // Reset while in RX
      send_cmd(CMD_READ, 4'd2, 8'h0);
      chk("rx leds", word_t'(leds), 'h1);
      tick();
      resetn = 1'b0;
      #1;
      check_zero("reset in RX");
      for (int i = 0; i < NO; i++) exp_ops[i] = '0;
      exp_err = 1'b0;
      tick();
      resetn = 1'b1;
      do_read("read after rx reset", 2, 'h7777);
      chk("slot2 after reset literal", op_regs[2*DATA_W +: DATA_W], 'h7777);

      // Reset while in TX
      do_start("enc core0 for tx", CMD_ENCRYPT, 0, 1'b1);
      exp_res = res_val[0];
      send_cmd(CMD_WRITE, 4'h0, 8'h0);
      n = 0;
      while (!arm.fpga_to_arm_data_valid && n < 60) begin
         tick();
         n++;
      end
      chk("tx reached", word_t'(arm.fpga_to_arm_data_valid), word_t'(1));
      chk("tx leds", word_t'(leds), 'h4);
      chk("tx data literal", arm.fpga_to_arm_data, 'h1234);
      tick();
      resetn = 1'b0;
      #1;
      check_zero("reset in TX");
      for (int i = 0; i < NO; i++) exp_ops[i] = '0;
      exp_err = 1'b0;
      tick();
      resetn = 1'b1;
      do_read("read after tx reset", 1, 'h9999);

      // Core 0 still holds its unacknowledged result
      do_start("enc core0 result held", CMD_ENCRYPT, 0, 1'b0);
      chk("leds after held result", word_t'(leds), 'h8);
      do_read("clear err 3", SLOT_MSG, 'h4242);
      chk("leds final", word_t'(leds), '0);

      chk("pending starts", word_t'(start_q.size()), '0);
      chk("pending acks", word_t'(ack_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
